// File: rtl/imem_arbiter_if.sv
// Signal bundle between the instruction-memory arbiter, its two requesters and the memory.
// The slave modport is the arbiter side; master is the requester/memory side.
interface imem_arbiter_if;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        l_req;
  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_gnt;
  logic        l_rvalid;
  logic [31:0] l_rdata;
  logic        err;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rd,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, err,
           mem_a, mem_we, mem_wd
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rd,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, err,
           mem_a, mem_we, mem_wd
  );
endinterface

// File: rtl/imem_arbiter.sv
// Shares one single-port instruction memory between CPU fetch (priority) and the loader port.
// Define IMEM_ARB_STARVE_EN to force a loader grant after MAX_WAIT consecutive denied cycles.
module imem_arbiter #(
  parameter int DEPTH    = 64,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  imem_arbiter_if.slave   bus,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, LOAD = 2'd2} owner_e;

  owner_e      state_q, state_d;
  logic        f_gnt, l_gnt, force_l;
  logic        f_bad, l_bad;
  logic        f_rvalid_q, f_rvalid_d;
  logic [31:0] f_rdata_q, f_rdata_d;
  logic        l_rvalid_q, l_rvalid_d;
  logic [31:0] l_rdata_q, l_rdata_d;
  logic        err_q, err_d;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
  endfunction

`ifdef IMEM_ARB_STARVE_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  assign force_l = (wait_cnt_q == WAIT_W'(MAX_WAIT));

  always_comb begin
    wait_cnt_d = '0;
    if (bus.l_req && !l_gnt)
      wait_cnt_d = force_l ? wait_cnt_q : wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wait_cnt_q <= '0;
    else          wait_cnt_q <= wait_cnt_d;
  end
`else
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT == 0);
  assign force_l         = 1'b0;
`endif

  // grant and memory mux are purely combinational
  assign f_gnt = bus.f_req & ~(bus.l_req & force_l);
  assign l_gnt = bus.l_req & (~bus.f_req | force_l);
  assign f_bad = addr_bad(bus.f_addr);
  assign l_bad = addr_bad(bus.l_addr);

  assign bus.f_gnt  = f_gnt;
  assign bus.l_gnt  = l_gnt;
  assign bus.mem_a  = f_gnt ? bus.f_addr : (l_gnt ? bus.l_addr : 32'h0);
  // bad-address writes and writes during reset never reach the array
  assign bus.mem_we = l_gnt & bus.l_we & ~l_bad & reset_n;
  assign bus.mem_wd = bus.l_wdata;

  always_comb begin
    f_rvalid_d = f_gnt;
    f_rdata_d  = f_rdata_q;
    l_rvalid_d = l_gnt & ~bus.l_we;
    l_rdata_d  = l_rdata_q;
    err_d      = (f_gnt & f_bad) | (l_gnt & l_bad);
    state_d    = IDLE;
    if (f_gnt) begin
      f_rdata_d = f_bad ? 32'h0 : bus.mem_rd;
      state_d   = FETCH;
    end else if (l_gnt) begin
      state_d = LOAD;
    end
    if (l_gnt && !bus.l_we)
      l_rdata_d = l_bad ? 32'h0 : bus.mem_rd;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      f_rvalid_q <= 1'b0;
      f_rdata_q  <= 32'h0;
      l_rvalid_q <= 1'b0;
      l_rdata_q  <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      f_rvalid_q <= f_rvalid_d;
      f_rdata_q  <= f_rdata_d;
      l_rvalid_q <= l_rvalid_d;
      l_rdata_q  <= l_rdata_d;
      err_q      <= err_d;
    end
  end

  assign bus.f_rvalid = f_rvalid_q;
  assign bus.f_rdata  = f_rdata_q;
  assign bus.l_rvalid = l_rvalid_q;
  assign bus.l_rdata  = l_rdata_q;
  assign bus.err      = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: a reference model predicts grants and next-cycle returns.
module tb_imem_arbiter;
  localparam int DEPTH    = 64;
  localparam int MAX_WAIT = 4;

  typedef struct {
    logic        fv;
    logic [31:0] fd;
    logic        lv;
    logic [31:0] ld;
    logic        er;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] dbg_state;

  imem_arbiter_if bus ();

  imem_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  logic [31:0] mem  [0:DEPTH-1];
  logic [31:0] gold [0:DEPTH-1];

  assign bus.mem_rd = (bus.mem_a[31:8] == 24'h0) ? mem[bus.mem_a[7:2]] : 32'hBAD0_BAD0;

  always @(posedge clk)
    if (bus.mem_we) mem[bus.mem_a[7:2]] <= bus.mem_wd;

  int n_chk = 0;
  int n_err = 0;
  int n_fg  = 0;
  int n_lg  = 0;
  exp_t sb[$];

  logic [31:0] m_fd = 32'h0;
  logic [31:0] m_ld = 32'h0;
  int          m_wait = 0;
  logic [1:0]  m_state = 2'd0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= DEPTH);
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return is_bad(a) ? 32'h0 : gold[a[7:2]];
  endfunction

  task automatic model_reset();
    m_fd = 32'h0; m_ld = 32'h0; m_wait = 0; m_state = 2'd0;
  endtask

  task automatic step(input logic fr, input logic [31:0] fa, input logic lr,
                      input logic lw, input logic [31:0] la, input logic [31:0] lwd);
    exp_t e;
    logic frc, fg, lg, lb;
    logic [31:0] ea;
    @(negedge clk);
    bus.f_req = fr; bus.f_addr = fa;
    bus.l_req = lr; bus.l_we = lw; bus.l_addr = la; bus.l_wdata = lwd;
    #1;
`ifdef IMEM_ARB_STARVE_EN
    frc = (m_wait == MAX_WAIT);
`else
    frc = 1'b0;
`endif
    fg = fr && !(lr && frc);
    lg = lr && (!fr || frc);
    lb = is_bad(la);
    ea = fg ? fa : (lg ? la : 32'h0);
    check_eq("f_gnt", bus.f_gnt, fg);
    check_eq("l_gnt", bus.l_gnt, lg);
    check_eq("mem_a", bus.mem_a, ea);
    check_eq("mem_we", bus.mem_we, lg && lw && !lb);
    check_eq("state", dbg_state, m_state);
    e.fv = fg;
    e.fd = fg ? rd_word(fa) : m_fd;
    e.lv = lg && !lw;
    e.ld = (lg && !lw) ? rd_word(la) : m_ld;
    e.er = (fg && is_bad(fa)) || (lg && lb);
    m_fd = e.fd; m_ld = e.ld;
    if (lg && lw && !lb) gold[la[7:2]] = lwd;
    if (lr && !lg) m_wait = (m_wait == MAX_WAIT) ? MAX_WAIT : m_wait + 1;
    else           m_wait = 0;
    m_state = fg ? 2'd1 : (lg ? 2'd2 : 2'd0);
    if (fg) n_fg++;
    if (lg) n_lg++;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("f_rvalid", bus.f_rvalid, e.fv);
    check_eq("f_rdata", bus.f_rdata, e.fd);
    check_eq("l_rvalid", bus.l_rvalid, e.lv);
    check_eq("l_rdata", bus.l_rdata, e.ld);
    check_eq("err", bus.err, e.er);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = 32'hA500_0000 + 32'(i * 3 + 1);
      gold[i] = 32'hA500_0000 + 32'(i * 3 + 1);
    end
    // reset state; grant still follows inputs but the write is blocked
    bus.f_req = 1'b0; bus.f_addr = 32'h0;
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h0; bus.l_wdata = 32'h1234_5678;
    #3;
    check_eq("rst_f_rvalid", bus.f_rvalid, 1'b0);
    check_eq("rst_l_rvalid", bus.l_rvalid, 1'b0);
    check_eq("rst_f_rdata", bus.f_rdata, 32'h0);
    check_eq("rst_l_rdata", bus.l_rdata, 32'h0);
    check_eq("rst_err", bus.err, 1'b0);
    check_eq("rst_state", dbg_state, 2'd0);
    check_eq("rst_l_gnt", bus.l_gnt, 1'b1);
    check_eq("rst_mem_we", bus.mem_we, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bus.l_req = 1'b0; bus.l_we = 1'b0;

    // fetch stream then idle
    step(1, 32'h0, 0, 0, 0, 0);
    step(1, 32'h4, 0, 0, 0, 0);
    step(1, 32'h8, 0, 0, 0, 0);
    step(0, 32'h0, 0, 0, 0, 0);

    // loader write then read-back of the same word
    step(0, 0, 1, 1, 32'h10, 32'hDEAD_BEEF);
    step(0, 0, 1, 0, 32'h10, 32'h0);
    check_eq("wr_rd_back", bus.l_rdata, 32'hDEAD_BEEF);
    step(0, 0, 0, 0, 32'h0, 32'h0);

    // sustained contention
    n_fg = 0; n_lg = 0;
    for (int i = 0; i < 10; i++) step(1, 32'(i * 4), 1, 0, 32'h10, 32'h0);
`ifdef IMEM_ARB_STARVE_EN
    check_eq("contend_l_grants", n_lg, 2);
    check_eq("contend_f_grants", n_fg, 8);
`else
    check_eq("contend_l_grants", n_lg, 0);
    check_eq("contend_f_grants", n_fg, 10);
`endif
    step(0, 0, 0, 0, 0, 0);

    // error cases and the last valid word
    step(1, 32'h102, 0, 0, 0, 0);
    step(1, 32'h100, 0, 0, 0, 0);
    step(0, 0, 1, 1, 32'h100, 32'hCAFE_F00D);
    step(0, 0, 1, 0, 32'h0, 32'h0);
    step(0, 0, 1, 0, 32'hFC, 32'h0);
    step(0, 0, 1, 0, 32'h103, 32'h0);
    step(1, 32'hFC, 0, 0, 0, 0);

    // idle cycles
    for (int i = 0; i < 3; i++) step(0, 32'h40, 0, 1, 32'h20, 32'h5555_AAAA);
    check_eq("idle_mem_a", bus.mem_a, 32'h0);

    // reset while a fetch return is pending
    @(negedge clk);
    bus.f_req = 1'b1; bus.f_addr = 32'h4;
    #1;
    check_eq("mid_f_gnt", bus.f_gnt, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check_eq("mid_f_rvalid", bus.f_rvalid, 1'b0);
    check_eq("mid_f_rdata", bus.f_rdata, 32'h0);
    check_eq("mid_state", dbg_state, 2'd0);
    @(posedge clk);
    #1;
    check_eq("mid_f_rvalid_edge", bus.f_rvalid, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.f_req = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_eq("post_rst_f_rvalid", bus.f_rvalid, 1'b0);
    check_eq("post_rst_f_rdata", bus.f_rdata, 32'h0);
    step(1, 32'h8, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end
endmodule
